// File: rtl/sm_pkg.sv
//------------------------------------------------------------------------------
// sm_pkg: shared types and helpers for the sign-magnitude add/subtract pipe
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sm_pkg;

  typedef enum logic [1:0] {
    GT = 2'd0,
    LT = 2'd1,
    EQ = 2'd2
  } mag_cmp_e;

  localparam int MAX_WIDTH = 64;

  // Callers zero-extend their magnitude into the widest supported field.
  function automatic logic mag_is_zero(input logic [MAX_WIDTH-2:0] mag);
    return (mag == '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sm_mag_addsub.sv
//------------------------------------------------------------------------------
// sm_mag_addsub: combinational magnitude add / ordered subtract
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sm_mag_addsub
  import sm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-2:0] a_mag,
  input  logic [WIDTH-2:0] b_mag,
  input  logic             op_add,
  input  mag_cmp_e         cmp,
  output logic [WIDTH-2:0] mag,
  output logic             carry
);

  always_comb begin
    mag   = '0;
    carry = 1'b0;
    if (op_add) begin
      {carry, mag} = {1'b0, a_mag} + {1'b0, b_mag};
    end else begin
      // Subtract the smaller from the larger so the difference never wraps.
      case (cmp)
        GT:      mag = a_mag - b_mag;
        LT:      mag = b_mag - a_mag;
        default: mag = '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/sm_addsub_pipe.sv
//------------------------------------------------------------------------------
// sm_addsub_pipe: two-stage valid/ready sign-magnitude adder/subtractor
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sm_addsub_pipe
  import sm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int MW = WIDTH - 1;

  logic          s1_en, s2_en;
  logic          s1_valid_q, s1_valid_d;
  logic [MW-1:0] s1_a_mag_q, s1_a_mag_d;
  logic [MW-1:0] s1_b_mag_q, s1_b_mag_d;
  logic          s1_a_sign_q, s1_a_sign_d;
  logic          s1_b_sign_q, s1_b_sign_d;
  logic          s1_op_add_q, s1_op_add_d;
  mag_cmp_e      s1_cmp_q, s1_cmp_d;
  logic          out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic          carry_q, carry_d;

  logic          in_b_sign;
  mag_cmp_e      in_cmp;
  logic [MW-1:0] res_mag;
  logic          res_carry;
  logic          res_sign;
  logic [MAX_WIDTH-2:0] res_mag_ext;

  sm_mag_addsub #(.WIDTH(WIDTH)) u_mag_addsub (
    .a_mag  (s1_a_mag_q),
    .b_mag  (s1_b_mag_q),
    .op_add (s1_op_add_q),
    .cmp    (s1_cmp_q),
    .mag    (res_mag),
    .carry  (res_carry)
  );

  always_comb begin
    s2_en = !out_valid_q || out_ready;
    s1_en = !s1_valid_q || s2_en;

    in_b_sign = B[WIDTH-1] ^ sub;
    if (A[MW-1:0] > B[MW-1:0])      in_cmp = GT;
    else if (A[MW-1:0] < B[MW-1:0]) in_cmp = LT;
    else                            in_cmp = EQ;

    s1_valid_d  = s1_en ? in_valid : s1_valid_q;
    s1_a_mag_d  = s1_a_mag_q;
    s1_b_mag_d  = s1_b_mag_q;
    s1_a_sign_d = s1_a_sign_q;
    s1_b_sign_d = s1_b_sign_q;
    s1_op_add_d = s1_op_add_q;
    s1_cmp_d    = s1_cmp_q;
    if (s1_en && in_valid) begin
      s1_a_mag_d  = A[MW-1:0];
      s1_b_mag_d  = B[MW-1:0];
      s1_a_sign_d = A[WIDTH-1];
      s1_b_sign_d = in_b_sign;
      s1_op_add_d = (A[WIDTH-1] == in_b_sign);
      s1_cmp_d    = in_cmp;
    end

    if (s1_op_add_q)           res_sign = s1_a_sign_q;
    else if (s1_cmp_q == GT)   res_sign = s1_a_sign_q;
    else if (s1_cmp_q == LT)   res_sign = s1_b_sign_q;
    else                       res_sign = 1'b0;

    // A zero magnitude without overflow always leaves with a positive sign.
    res_mag_ext          = '0;
    res_mag_ext[MW-1:0]  = res_mag;
    if (!res_carry && mag_is_zero(res_mag_ext)) res_sign = 1'b0;

    out_valid_d = s2_en ? s1_valid_q : out_valid_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    if (s2_en && s1_valid_q) begin
      sum_d   = {res_sign, res_mag};
      carry_d = res_carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
    end
  end

  always_ff @(posedge clk) begin
    s1_a_mag_q  <= s1_a_mag_d;
    s1_b_mag_q  <= s1_b_mag_d;
    s1_a_sign_q <= s1_a_sign_d;
    s1_b_sign_q <= s1_b_sign_d;
    s1_op_add_q <= s1_op_add_d;
    s1_cmp_q    <= s1_cmp_d;
  end

  assign in_ready  = s1_en;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carry     = carry_q;

endmodule

`default_nettype wire

// File: tb/tb_sm_addsub_pipe.sv
//------------------------------------------------------------------------------
// tb_sm_addsub_pipe: directed and randomized checks against a signed-integer model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sm_addsub_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] A, B;
  logic       sub;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       carry;

  int n_vec = 0;
  int n_err = 0;

  sm_addsub_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: interpret operands as signed integers, do the arithmetic, re-encode.
  function automatic logic [8:0] ref_model(input logic [7:0] a, input logic [7:0] b, input logic s);
    int va, vb, r, m;
    logic [6:0] mag;
    va = int'(a[6:0]);
    if (a[7]) va = -va;
    vb = int'(b[6:0]);
    if (b[7]) vb = -vb;
    r = s ? (va - vb) : (va + vb);
    m = (r < 0) ? -r : r;
    mag = 7'(m);
    return {(m > 127), (r < 0), mag};
  endfunction

  task automatic directed(input logic [7:0] a, input logic [7:0] b, input logic s, input string tag);
    A = a; B = b; sub = s; in_valid = 1'b1; out_ready = 1'b1;
    #1 check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq({tag, "_early"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_eq(tag, 32'({carry, sum}), 32'(ref_model(a, b, s)));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [8:0] q[$];
    logic [8:0] e0, e1, e2, exp;
    int sent, got, cyc;
    bit acc, outf;
    const int TOTAL = 6000;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; sub = 1'b0;
    #2;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_sum", 32'(sum), 32'd0);
    check_eq("rst_carry", 32'(carry), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    check_eq("rel_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    directed(8'h05, 8'h83, 1'b0, "d_05p83");
    directed(8'h03, 8'h85, 1'b0, "d_03p85");
    directed(8'h40, 8'h40, 1'b0, "d_40p40");
    directed(8'hC0, 8'hC0, 1'b0, "d_C0pC0");
    directed(8'h85, 8'h05, 1'b0, "d_85p05");
    directed(8'h80, 8'h80, 1'b0, "d_80p80");
    directed(8'h05, 8'h05, 1'b1, "d_05m05");
    directed(8'h05, 8'h83, 1'b1, "d_05m83");
    check_eq("d_known_C0", 32'(ref_model(8'hC0, 8'hC0, 1'b0)), 32'h180);

    // Backpressure: three beats offered while the consumer stalls.
    e0 = ref_model(8'h11, 8'h22, 1'b0);
    e1 = ref_model(8'h7F, 8'h01, 1'b0);
    e2 = ref_model(8'h10, 8'h95, 1'b1);
    out_ready = 1'b0;
    A = 8'h11; B = 8'h22; sub = 1'b0; in_valid = 1'b1;
    #1 check_eq("bp_acc0", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    A = 8'h7F; B = 8'h01; sub = 1'b0;
    check_eq("bp_acc1", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    A = 8'h10; B = 8'h95; sub = 1'b1;
    check_eq("bp_full", 32'(in_ready), 32'd0);
    check_eq("bp_hold0", 32'({out_valid, carry, sum}), 32'({1'b1, e0}));
    @(posedge clk); #1;
    check_eq("bp_full2", 32'(in_ready), 32'd0);
    check_eq("bp_hold1", 32'({out_valid, carry, sum}), 32'({1'b1, e0}));
    out_ready = 1'b1;
    #1 check_eq("bp_acc2", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("bp_drain1", 32'({out_valid, carry, sum}), 32'({1'b1, e1}));
    @(posedge clk); #1;
    check_eq("bp_drain2", 32'({out_valid, carry, sum}), 32'({1'b1, e2}));
    @(posedge clk); #1;
    check_eq("bp_empty", 32'(out_valid), 32'd0);

    // Reset with two beats in flight.
    A = 8'h21; B = 8'h12; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    A = 8'h33; B = 8'h44; sub = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", 32'(out_valid), 32'd0);
    check_eq("arst_sum", 32'({carry, sum}), 32'd0);
    check_eq("arst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("post_rst_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;

    // Randomized streaming with random backpressure.
    sent = 0; got = 0; cyc = 0;
    in_valid = 1'b0;
    while (got < TOTAL && cyc < 40000) begin
      @(negedge clk);
      acc  = in_valid && in_ready;
      outf = out_valid && out_ready;
      if (outf) begin
        if (q.size() == 0) begin
          check_eq("spurious_out", 32'd1, 32'd0);
        end else begin
          exp = q.pop_front();
          check_eq("stream", 32'({carry, sum}), 32'(exp));
        end
        got++;
      end
      if (acc) begin
        q.push_back(ref_model(A, B, sub));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
      out_ready = ($urandom_range(0, 3) != 0);
      if (acc || !in_valid) begin
        if (sent < TOTAL && $urandom_range(0, 7) != 0) begin
          in_valid = 1'b1;
          A   = 8'($urandom);
          B   = 8'($urandom);
          sub = 1'($urandom);
          if ($urandom_range(0, 7) == 0) A[6:0] = ($urandom_range(0, 1) != 0) ? 7'h7F : 7'h00;
          if ($urandom_range(0, 7) == 0) B[6:0] = A[6:0];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    check_eq("stream_count", 32'(got), 32'(TOTAL));
    check_eq("stream_leftover", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sm_addsub_pipe.md
SM_ADDSUB_PIPE -- requirements
Module: sm_addsub_pipe

Interface
REQ-001 Parameter WIDTH, default 8: total operand and result width; bit WIDTH-1 is the sign, bits WIDTH-2:0 are the magnitude; legal range 2..64.
REQ-002 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 Port in_valid, input, 1: the operand beat on A, B and sub is valid.
REQ-005 Port in_ready, output, 1: the block accepts the beat this cycle.
REQ-006 Port A, input, WIDTH: sign-magnitude operand A.
REQ-007 Port B, input, WIDTH: sign-magnitude operand B.
REQ-008 Port sub, input, 1: 0 = A+B, 1 = A-B.
REQ-009 Port out_valid, output, 1: sum and carry are valid.
REQ-010 Port out_ready, input, 1: the downstream consumer accepts the result.
REQ-011 Port sum, output, WIDTH: sign-magnitude result.
REQ-012 Port carry, output, 1: magnitude overflow; set when the magnitude result needs more than WIDTH-1 bits.

Function
REQ-013 An input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
REQ-014 Two-stage pipeline. Stage 1 registers the effective B sign (B[WIDTH-1] ^ sub), the operation (effective add when the signs match) and the magnitude comparison (A>B, B>A or equal). Stage 2 registers sum and carry.
REQ-015 Latency: a beat accepted in cycle N presents out_valid in cycle N+2 when out_ready is held high.
REQ-016 Throughput is one beat per cycle with no bubbles while out_ready=1.
REQ-017 Stage-2 load enable s2_en = !s2_valid || out_ready; stage-1 load enable s1_en = !s1_valid || s2_en.
REQ-018 in_ready = s1_en, and in_ready shall not depend combinationally on in_valid.
REQ-019 While out_valid && !out_ready, sum, carry and out_valid shall hold stable.
REQ-020 Under backpressure at most 2 beats are buffered, and no beat is ever dropped or duplicated.
REQ-021 Matching effective signs: {carry, mag} = A_mag + B_mag, truncated to WIDTH-1 magnitude bits; sign = A sign.
REQ-022 Differing effective signs, A_mag > B_mag: mag = A_mag - B_mag, sign = A sign, carry = 0.
REQ-023 Differing effective signs, B_mag > A_mag: mag = B_mag - A_mag, sign = effective B sign, carry = 0.
REQ-024 Differing effective signs, equal magnitudes: result is all zeros, carry = 0.
REQ-025 Zero normalisation: when mag == 0 and carry == 0, the sign bit shall be 0, so negative zero is never output.
REQ-026 Negative-zero inputs are treated as magnitude zero.
REQ-027 When both stages advance in the same cycle, stage 2 captures the old stage-1 contents and stage 1 captures the new input.

Reset
REQ-028 Asserting rst_n low immediately clears the stage-1 valid, stage-2 valid, out_valid, sum and carry registers to 0, independent of clk.
REQ-029 in_ready is 1 while reset is asserted and in the first cycle after release.
REQ-030 Beats in flight when reset asserts are discarded, and no out_valid pulse follows reset release.
REQ-031 Datapath registers other than sum and carry need no reset.

Structure
REQ-032 Shared package sm_pkg holds the magnitude-compare result enum (GT, LT, EQ) and a function for the sign-magnitude zero check.
REQ-033 The pure combinational magnitude add/subtract (inputs: two magnitudes, the operation, the compare result; outputs: magnitude, carry) is one sub-module, sm_mag_addsub, parametrised by WIDTH.
REQ-034 The pipeline registers and handshake logic live in sm_addsub_pipe.

Verification (WIDTH=8, out_ready=1 unless stated)
REQ-035 A=0x05, B=0x83, sub=0 -> sum=0x02, carry=0. A=0x03, B=0x85, sub=0 -> sum=0x82, carry=0. Both appear exactly 2 cycles after acceptance.
REQ-036 A=0x40, B=0x40 -> sum=0x00, carry=1. A=0xC0, B=0xC0 -> sum=0x80, carry=1.
REQ-037 A=0x85, B=0x05, sub=0 -> sum=0x00. A=0x80, B=0x80 -> sum=0x00. A=0x05, B=0x05, sub=1 -> sum=0x00. A=0x05, B=0x83, sub=1 -> sum=0x08.
REQ-038 Backpressure: out_ready=0, present 3 back-to-back beats -> 2 beats accepted, then in_ready=0; sum holds the first result. Raise out_ready -> results drain in order with no loss.
REQ-039 Reset: assert rst_n=0 with 2 beats in flight -> out_valid=0, sum=0x00, carry=0 at once; after release, no stale output appears.
REQ-040 Exhaustive sweep: all 65536 (A, B) pairs for each sub value, streamed at one beat per cycle with random out_ready -> every output matches a reference model implementing REQ-021..REQ-026.
